// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack data memory.
// Holds the clear/run state, the address regions and the address decoder.
package hack_mem_pkg;

  localparam int SCREEN_BASE = 16384;
  localparam int KBD_ADDR    = 24576;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_ILLEGAL
  } region_e;

  // Bit 15 set is never a valid data address, whatever the sizes are.
  function automatic region_e decode(
    input logic [15:0] a,
    input int          ram_words,
    input int          kbd_addr
  );
    logic [31:0] a32;
    a32 = {16'h0000, a};
    if (a[15])
      return REG_ILLEGAL;
    else if (a32 < 32'(ram_words))
      return REG_RAM;
    else if (a32 < 32'(kbd_addr))
      return REG_SCREEN;
    else if (a32 == 32'(kbd_addr))
      return REG_KBD;
    else
      return REG_ILLEGAL;
  endfunction

endpackage

// File: rtl/hack_data_memory_if.sv
// CPU data port plus keyboard valid/ready handshake.
// master: CPU and keyboard decoder side; slave: the data memory.
interface hack_data_memory_if;

  logic [15:0] addrM;
  logic [15:0] outM;
  logic        WriteM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_ready;

  modport master (
    output addrM,
    output outM,
    output WriteM,
    input  inM,
    output kbd_valid,
    output kbd_code,
    input  kbd_ready
  );

  modport slave (
    input  addrM,
    input  outM,
    input  WriteM,
    output inM,
    input  kbd_valid,
    input  kbd_code,
    output kbd_ready
  );

endinterface

// File: rtl/hack_data_memory_dp_ram.sv
// Word RAM: one sync write port, one combinational read port and one
// registered read port (read-before-write). i_dzero forces the latter to 0.
module hack_dp_ram #(
  parameter int WORDS = 16,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata,
  input  logic [AW-1:0] i_daddr,
  input  logic          i_dzero,
  output logic [15:0]   o_ddata
);

  logic [15:0] r_mem [WORDS];
  logic [15:0] r_ddata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_dzero)
      r_ddata <= '0;
    else
      r_ddata <= r_mem[i_daddr];
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_ddata = r_ddata;

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen, keyboard register, clear-on-reset FSM.
// Ports: clk, rst, bus (CPU + keyboard), busy, disp_addr/disp_data, addr_err.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS    = SCREEN_BASE,
  parameter int SCREEN_WORDS = KBD_ADDR - SCREEN_BASE
) (
  input  logic                            clk,
  input  logic                            rst,
  hack_data_memory_if.slave               bus,
  output logic                            busy,
  input  logic [$clog2(SCREEN_WORDS)-1:0] disp_addr,
  output logic [15:0]                     disp_data,
  output logic                            addr_err
);

  localparam int TOTAL = RAM_WORDS + SCREEN_WORDS;
  localparam int KBD_A = TOTAL;
  localparam int RAW   = $clog2(RAM_WORDS);
  localparam int SAW   = $clog2(SCREEN_WORDS);
  localparam int CW    = $clog2(TOTAL);

  state_e          r_state;
  logic [CW-1:0]   r_clr_cnt;
  logic            r_busy;
  logic            r_kbd_ready;
  logic [15:0]     r_kbd;
  logic            r_addr_err;

  region_e         w_region;
  logic [RAW-1:0]  w_ram_idx;
  logic [SAW-1:0]  w_scr_idx;
  logic [RAW-1:0]  w_clr_ram;
  logic [SAW-1:0]  w_clr_scr;
  logic            w_clr_in_ram;

  logic            w_ram_we;
  logic [RAW-1:0]  w_ram_waddr;
  logic [15:0]     w_ram_wdata;
  logic [15:0]     w_ram_rd;
  logic            w_scr_we;
  logic [SAW-1:0]  w_scr_waddr;
  logic [15:0]     w_scr_wdata;
  logic [15:0]     w_scr_rd;
  logic [15:0]     w_ram_disp;
  logic            w_dzero;
  logic [15:0]     w_inM;

  assign w_region     = decode(bus.addrM, RAM_WORDS, KBD_A);
  assign w_ram_idx    = RAW'(bus.addrM);
  assign w_scr_idx    = SAW'(bus.addrM - 16'(RAM_WORDS));
  assign w_clr_ram    = RAW'(r_clr_cnt);
  assign w_clr_scr    = SAW'(r_clr_cnt - CW'(RAM_WORDS));
  assign w_clr_in_ram = (r_clr_cnt < CW'(RAM_WORDS));

  // Display read is zeroed while clearing, so the word caught
  // on the final clear edge never leaks out.
  assign w_dzero = rst | (r_state == CLEAR);

  // Write port mux: clear walker owns both arrays in CLEAR,
  // CPU owns them in RUN; reset drops everything.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = '0;
    w_ram_wdata = '0;
    w_scr_we    = 1'b0;
    w_scr_waddr = '0;
    w_scr_wdata = '0;
    if (!rst) begin
      if (r_state == CLEAR) begin
        if (w_clr_in_ram) begin
          w_ram_we    = 1'b1;
          w_ram_waddr = w_clr_ram;
        end else begin
          w_scr_we    = 1'b1;
          w_scr_waddr = w_clr_scr;
        end
      end else if (bus.WriteM) begin
        unique case (1'b1)
          (w_region == REG_RAM): begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_ram_idx;
            w_ram_wdata = bus.outM;
          end
          (w_region == REG_SCREEN): begin
            w_scr_we    = 1'b1;
            w_scr_waddr = w_scr_idx;
            w_scr_wdata = bus.outM;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_inM = '0;
    if (r_state == RUN) begin
      unique case (w_region)
        REG_RAM:    w_inM = w_ram_rd;
        REG_SCREEN: w_inM = w_scr_rd;
        REG_KBD:    w_inM = r_kbd;
        default:    w_inM = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_busy      <= 1'b1;
      r_kbd_ready <= 1'b0;
      r_kbd       <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          if (r_clr_cnt == CW'(TOTAL - 1)) begin
            r_state     <= RUN;
            r_busy      <= 1'b0;
            r_kbd_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + CW'(1);
          end
        end
        RUN: begin
          if (bus.WriteM &&
              (w_region == REG_KBD ||
               w_region == REG_ILLEGAL))
            r_addr_err <= 1'b1;
          if (bus.kbd_valid && r_kbd_ready)
            r_kbd <= bus.kbd_code;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  hack_dp_ram #(
    .WORDS(RAM_WORDS)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_waddr(w_ram_waddr),
    .i_wdata(w_ram_wdata),
    .i_raddr(w_ram_idx),
    .o_rdata(w_ram_rd),
    .i_daddr(w_ram_idx),
    .i_dzero(1'b1),
    .o_ddata(w_ram_disp)
  );

  hack_dp_ram #(
    .WORDS(SCREEN_WORDS)
  ) u_scr (
    .clk    (clk),
    .i_we   (w_scr_we),
    .i_waddr(w_scr_waddr),
    .i_wdata(w_scr_wdata),
    .i_raddr(w_scr_idx),
    .o_rdata(w_scr_rd),
    .i_daddr(disp_addr),
    .i_dzero(w_dzero),
    .o_ddata(disp_data)
  );

  // RAM has no display consumer; its registered port is held at 0.
  logic w_unused;
  assign w_unused = |w_ram_disp;

  assign bus.inM       = w_inM;
  assign bus.kbd_ready = r_kbd_ready;
  assign busy          = r_busy;
  assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory with a 16-word RAM and 8-word screen.
// Inputs change 1 time unit after the rising edge; outputs are checked after.
module tb_hack_data_memory;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [2:0] disp_addr;
  logic [15:0] disp_data;
  logic       addr_err;

  int total;
  int bad;

  hack_data_memory_if bus();

  hack_data_memory #(
    .RAM_WORDS   (16),
    .SCREEN_WORDS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy got=%b want=1", busy);
    end
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL reset_inM got=%h want=0000", bus.inM);
    end
    total++;
    if (bus.kbd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_kbd_ready got=%b want=0", bus.kbd_ready);
    end
    total++;
    if (disp_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_disp got=%h want=0000", disp_data);
    end
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_addr_err got=%b want=0", addr_err);
    end
    count_busy(n);
    total++;
    if (n != 24) begin
      bad++;
      $display("FAIL clear_cycles got=%0d want=24", n);
    end
    total++;
    if (bus.kbd_ready !== 1'b1) begin
      bad++;
      $display("FAIL run_kbd_ready got=%b want=1", bus.kbd_ready);
    end
    total++;
    if (disp_data !== 16'h0000) begin
      bad++;
      $display("FAIL run_disp got=%h want=0000", disp_data);
    end
    for (int a = 0; a < 24; a++) begin
      bus.addrM = 16'(a);
      #1;
      total++;
      if (bus.inM !== 16'h0000) begin
        bad++;
        $display("FAIL cleared_word a=%0d got=%h want=0000", a, bus.inM);
      end
    end
  endtask

  task automatic test_write_read;
    bus.addrM  = 16'd15;
    bus.outM   = 16'd15;
    bus.WriteM = 1'b1;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL wr15_same_cycle got=%h want=0000", bus.inM);
    end
    tick();
    bus.WriteM = 1'b0;
    #1;
    total++;
    if (bus.inM !== 16'd15) begin
      bad++;
      $display("FAIL wr15_next got=%h want=000f", bus.inM);
    end
    bus.addrM  = 16'd1;
    bus.WriteM = 1'b1;
    tick();
    bus.WriteM = 1'b0;
    #1;
    total++;
    if (bus.inM !== 16'd15) begin
      bad++;
      $display("FAIL wr_a1 got=%h want=000f", bus.inM);
    end
    bus.addrM  = 16'd23;
    bus.outM   = 16'hBEEF;
    bus.WriteM = 1'b1;
    tick();
    bus.WriteM = 1'b0;
    #1;
    total++;
    if (bus.inM !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_a23 got=%h want=beef", bus.inM);
    end
    bus.addrM = 16'd7;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL untouched_a7 got=%h want=0000", bus.inM);
    end
  endtask

  task automatic test_display;
    bus.addrM  = 16'd16;
    bus.outM   = 16'hAAAA;
    bus.WriteM = 1'b1;
    tick();
    bus.WriteM = 1'b0;
    disp_addr  = 3'd0;
    tick();
    total++;
    if (disp_data !== 16'hAAAA) begin
      bad++;
      $display("FAIL disp_a0 got=%h want=aaaa", disp_data);
    end
    total++;
    if (bus.inM !== 16'hAAAA) begin
      bad++;
      $display("FAIL cpu_a16 got=%h want=aaaa", bus.inM);
    end
    disp_addr  = 3'd1;
    bus.addrM  = 16'd17;
    bus.outM   = 16'h5555;
    bus.WriteM = 1'b1;
    tick();
    bus.WriteM = 1'b0;
    total++;
    if (disp_data !== 16'h0000) begin
      bad++;
      $display("FAIL disp_rbw got=%h want=0000", disp_data);
    end
    tick();
    total++;
    if (disp_data !== 16'h5555) begin
      bad++;
      $display("FAIL disp_after got=%h want=5555", disp_data);
    end
    disp_addr = 3'd7;
    tick();
    total++;
    if (disp_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL disp_a7 got=%h want=beef", disp_data);
    end
  endtask

  task automatic test_keyboard;
    bus.addrM     = 16'd24;
    bus.kbd_code  = 16'h0041;
    bus.kbd_valid = 1'b1;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL kbd_same_cycle got=%h want=0000", bus.inM);
    end
    tick();
    bus.kbd_valid = 1'b0;
    bus.kbd_code  = 16'h0099;
    #1;
    total++;
    if (bus.inM !== 16'h0041) begin
      bad++;
      $display("FAIL kbd_load got=%h want=0041", bus.inM);
    end
    tick();
    tick();
    total++;
    if (bus.inM !== 16'h0041) begin
      bad++;
      $display("FAIL kbd_hold got=%h want=0041", bus.inM);
    end
    bus.kbd_code  = 16'h0000;
    bus.kbd_valid = 1'b1;
    tick();
    bus.kbd_valid = 1'b0;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL kbd_release got=%h want=0000", bus.inM);
    end
  endtask

  task automatic test_illegal;
    bus.addrM     = 16'd24;
    bus.kbd_code  = 16'h0041;
    bus.kbd_valid = 1'b1;
    tick();
    bus.kbd_valid = 1'b0;
    #1;
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL err_before got=%b want=0", addr_err);
    end
    bus.outM   = 16'hFFFF;
    bus.WriteM = 1'b1;
    tick();
    bus.WriteM = 1'b0;
    #1;
    total++;
    if (bus.inM !== 16'h0041) begin
      bad++;
      $display("FAIL kbd_wr_ignored got=%h want=0041", bus.inM);
    end
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("FAIL err_set got=%b want=1", addr_err);
    end
    bus.addrM = 16'h8000;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL rd_8000 got=%h want=0000", bus.inM);
    end
    bus.addrM = 16'd25;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL rd_25 got=%h want=0000", bus.inM);
    end
    tick();
    tick();
    tick();
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b want=1", addr_err);
    end
  endtask

  task automatic test_midclear;
    int n;
    bus.addrM  = 16'd1;
    bus.outM   = 16'h1111;
    bus.WriteM = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.WriteM = 1'b0;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL clear_inM got=%h want=0000", bus.inM);
    end
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared got=%b want=0", addr_err);
    end
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.addrM  = 16'd5;
    bus.outM   = 16'h7777;
    bus.WriteM = 1'b1;
    count_busy(n);
    bus.WriteM = 1'b0;
    #1;
    total++;
    if (n != 24) begin
      bad++;
      $display("FAIL midclear_cycles got=%0d want=24", n);
    end
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL clear_wr_dropped got=%h want=0000", bus.inM);
    end
    bus.addrM = 16'd1;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL a1_cleared got=%h want=0000", bus.inM);
    end
    bus.addrM = 16'd24;
    #1;
    total++;
    if (bus.inM !== 16'h0000) begin
      bad++;
      $display("FAIL kbd_cleared got=%h want=0000", bus.inM);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    disp_addr     = 3'd0;
    bus.addrM     = 16'd0;
    bus.outM      = 16'd0;
    bus.WriteM    = 1'b0;
    bus.kbd_valid = 1'b0;
    bus.kbd_code  = 16'd0;
    tick();
    test_reset();
    test_write_read();
    test_display();
    test_keyboard();
    test_illegal();
    test_midclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
